// File: rtl/accelerator_pkg.sv
// Shared definitions for the low-rank-predicted sparse accelerator.
// Holds the address map, bus widths, array limits, the state enum and the
// 16-bit saturation helper used by both the projection and dot paths.
package accelerator_pkg;

  localparam int NUM_IN   = 64;
  localparam int MAX_OUT  = 4096;
  localparam int MAX_RANK = 8;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int RDATA_W = 32;
  localparam int ACC_W   = 40;

  localparam logic [ADDR_W-1:0] ADDR_IN_ACT_NO  = 16'hF000;
  localparam logic [ADDR_W-1:0] ADDR_OUT_ACT_NO = 16'hF001;
  localparam logic [ADDR_W-1:0] ADDR_RANK       = 16'hF002;
  localparam logic [ADDR_W-1:0] ADDR_SHIFT      = 16'hF003;
  localparam logic [ADDR_W-1:0] ADDR_START      = 16'hF004;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef enum logic [2:0] {IDLE, PROJ, PRED, DOT, STORE, DONE} state_t;

  // Clamp a 40-bit accumulator value into the signed 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return 16'sh7FFF;
    if (x < SAT_MIN) return 16'sh8000;
    return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/accel_mac.sv
// Signed 16x16 multiply feeding a 40-bit accumulator.
// sum_o is the combinational next value (restarting from zero when clr_i),
// so the caller can consume the final sum in the same cycle as the last MAC.
module accel_mac
  import accelerator_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = a_i * b_i;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign sum_o    = (clr_i ? 40'sd0 : acc_q) + prod_ext;

  // Accumulator only advances on cycles that actually issue a MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 40'sd0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/accelerator.sv
// Low-rank predicted ReLU layer: project inputs through v_mem, predict the sign
// of each output through u_mem, and only run the full w_mem dot product when
// the prediction is positive. Config and inputs are written over a simple
// strobe bus while idle; results are read back with a valid/ready handshake.
module accelerator
  import accelerator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               interrupt,
  input  logic               write_en,
  output logic               write_rdy,
  input  logic [ADDR_W-1:0]  write_addr,
  input  logic [DATA_W-1:0]  write_data,
  input  logic               read_en,
  output logic               read_rdy,
  input  logic [ADDR_W-1:0]  read_addr,
  input  logic               read_data_rdy,
  output logic               read_data_vld,
  output logic [RDATA_W-1:0] read_data
);

  // Weight stores are loaded externally and only ever read here.
  logic signed [DATA_W-1:0] w_mem   [MAX_OUT][NUM_IN];
  logic signed [DATA_W-1:0] u_mem   [MAX_OUT][MAX_RANK];
  logic signed [DATA_W-1:0] v_mem   [MAX_RANK][NUM_IN];
  logic signed [DATA_W-1:0] out_mem [MAX_OUT];

  state_t                   state_q;
  logic                     interrupt_q;
  logic signed [DATA_W-1:0] in_q [NUM_IN];
  logic signed [DATA_W-1:0] t_q  [MAX_RANK];
  logic [6:0]               in_act_no_q;
  logic [12:0]              out_act_no_q;
  logic [3:0]               rank_q;
  logic [3:0]               shift_q;
  logic [6:0]               j_q;
  logic [3:0]               r_q;
  logic [11:0]              k_q;
  logic signed [DATA_W-1:0] res_q;
  logic signed [DATA_W-1:0] w_op_q;
  logic signed [DATA_W-1:0] x_op_q;
  logic                     rd_vld_q;
  logic [RDATA_W-1:0]       rd_data_q;

  logic                     wr_fire;
  logic                     start;
  logic [6:0]               in_eff;
  logic [12:0]              out_eff;
  logic                     j_last;
  logic                     dot_last;
  logic                     r_last;
  logic                     k_last;
  logic                     mac_en;
  logic                     mac_clr;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  dot_relu;
  logic signed [DATA_W-1:0] dot_res;
  logic signed [DATA_W-1:0] proj_res;
  logic [11:0]              rd_k;
  logic signed [DATA_W-1:0] rd_val;
  logic                     unused_rd_bits;

  assign write_rdy     = (state_q == IDLE);
  assign read_rdy      = (state_q == IDLE) && !rd_vld_q;
  assign interrupt     = interrupt_q;
  assign read_data_vld = rd_vld_q;
  assign read_data     = rd_data_q;

  assign wr_fire = write_en && write_rdy;
  assign start   = wr_fire && (write_addr == ADDR_START) && write_data[0];

  // A zero count (reset value) behaves as a single element.
  assign in_eff   = (in_act_no_q == 7'd0) ? 7'd1 : in_act_no_q;
  assign out_eff  = (out_act_no_q == 13'd0) ? 13'd1 : out_act_no_q;
  assign j_last   = (j_q == in_eff - 7'd1);
  assign dot_last = (j_q == in_eff);
  assign r_last   = (r_q == rank_q - 4'd1);
  assign k_last   = ({1'b0, k_q} == out_eff - 13'd1);

  assign dot_relu = mac_sum[ACC_W-1] ? 40'sd0 : mac_sum;
  assign dot_res  = sat16(dot_relu >>> shift_q);
  assign proj_res = sat16(mac_sum >>> shift_q);

  // Read address packs the PE index high and the entry low; k = entry*64 + pe.
  assign rd_k           = {read_addr[5:0], read_addr[15:10]};
  assign rd_val         = ({1'b0, rd_k} < out_act_no_q) ? out_mem[rd_k] : 16'sd0;
  assign unused_rd_bits = ^read_addr[9:6];

  // Operand select for the shared MAC. DOT operands come from a one-cycle
  // fetch register because w_mem is large enough to be a synchronous RAM.
  always_comb begin
    mac_en  = 1'b0;
    mac_clr = 1'b0;
    mac_a   = 16'sd0;
    mac_b   = 16'sd0;
    case (state_q)
      PROJ: begin
        mac_en  = 1'b1;
        mac_clr = (j_q == 7'd0);
        mac_a   = v_mem[r_q[2:0]][j_q[5:0]];
        mac_b   = in_q[j_q[5:0]];
      end
      PRED: begin
        mac_en  = (rank_q != 4'd0);
        mac_clr = (r_q == 4'd0);
        mac_a   = u_mem[k_q][r_q[2:0]];
        mac_b   = t_q[r_q[2:0]];
      end
      DOT: begin
        mac_en  = (j_q != 7'd0);
        mac_clr = (j_q == 7'd1);
        mac_a   = w_op_q;
        mac_b   = x_op_q;
      end
      default: ;
    endcase
  end

  accel_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .sum_o (mac_sum)
  );

  // Control FSM: register writes while idle, then project/predict/dot/store per output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      interrupt_q  <= 1'b0;
      in_act_no_q  <= '0;
      out_act_no_q <= '0;
      rank_q       <= '0;
      shift_q      <= '0;
      j_q          <= '0;
      r_q          <= '0;
      k_q          <= '0;
      res_q        <= '0;
      w_op_q       <= '0;
      x_op_q       <= '0;
      for (int i = 0; i < NUM_IN; i++) in_q[i] <= '0;
      for (int i = 0; i < MAX_RANK; i++) t_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_fire) begin
            if (write_addr[15:6] == 10'd0) begin
              in_q[write_addr[5:0]] <= write_data;
            end else begin
              case (write_addr)
                ADDR_IN_ACT_NO:  in_act_no_q  <= (write_data > 16'd64) ? 7'd64 : write_data[6:0];
                ADDR_OUT_ACT_NO: out_act_no_q <= (write_data > 16'd4096) ? 13'd4096 : write_data[12:0];
                ADDR_RANK:       rank_q       <= (write_data > 16'd8) ? 4'd8 : write_data[3:0];
                ADDR_SHIFT:      shift_q      <= write_data[3:0];
                default: ;
              endcase
            end
          end
          if (start) begin
            interrupt_q <= 1'b0;
            j_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            state_q     <= (rank_q != 4'd0) ? PROJ : PRED;
          end
        end
        PROJ: begin
          if (j_last) begin
            t_q[r_q[2:0]] <= proj_res;
            j_q           <= '0;
            if (r_last) begin
              r_q     <= '0;
              state_q <= PRED;
            end else begin
              r_q <= r_q + 4'd1;
            end
          end else begin
            j_q <= j_q + 7'd1;
          end
        end
        PRED: begin
          if (rank_q == 4'd0) begin
            j_q     <= '0;
            state_q <= DOT;
          end else if (r_last) begin
            r_q <= '0;
            if (mac_sum <= 40'sd0) begin
              res_q   <= '0;
              state_q <= STORE;
            end else begin
              j_q     <= '0;
              state_q <= DOT;
            end
          end else begin
            r_q <= r_q + 4'd1;
          end
        end
        DOT: begin
          w_op_q <= w_mem[k_q][j_q[5:0]];
          x_op_q <= in_q[j_q[5:0]];
          if (dot_last) begin
            res_q   <= dot_res;
            state_q <= STORE;
          end else begin
            j_q <= j_q + 7'd1;
          end
        end
        STORE: begin
          if (k_last) begin
            state_q <= DONE;
          end else begin
            k_q     <= k_q + 12'd1;
            r_q     <= '0;
            j_q     <= '0;
            state_q <= PRED;
          end
        end
        DONE: begin
          interrupt_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == STORE) begin
      out_mem[k_q] <= res_q;
    end
  end

  // Read port: capture on accept, hold until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else if (read_en && read_rdy) begin
      rd_vld_q  <= 1'b1;
      rd_data_q <= {4'b0000, rd_k, rd_val};
    end else if (rd_vld_q && read_data_rdy) begin
      rd_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accelerator.sv
// Self-checking bench for accelerator: directed scenarios plus randomized
// configurations checked against a plain-arithmetic reference model.
module tb_accelerator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt;
  logic        write_en = 1'b0;
  logic        write_rdy;
  logic [15:0] write_addr = '0;
  logic [15:0] write_data = '0;
  logic        read_en = 1'b0;
  logic        read_rdy;
  logic [15:0] read_addr = '0;
  logic        read_data_rdy = 1'b0;
  logic        read_data_vld;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  // Bench-side copies of everything loaded into the DUT.
  int tb_w [128][64];
  int tb_u [128][8];
  int tb_v [8][64];
  int m_in [64];
  int m_inn, m_outn, m_rank, m_shift;
  logic [15:0] exp_out [128];
  int basic_cycles;

  always #5 clk = ~clk;

  accelerator dut (
    .clk           (clk),
    .rst           (rst),
    .interrupt     (interrupt),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_en       (read_en),
    .read_rdy      (read_rdy),
    .read_addr     (read_addr),
    .read_data_rdy (read_data_rdy),
    .read_data_vld (read_data_vld),
    .read_data     (read_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference: predictor decides whether the ReLU dot product is evaluated.
  function automatic logic [15:0] model_out(input int k);
    longint t [8];
    longint acc;
    longint p;
    if (m_rank > 0) begin
      for (int r = 0; r < m_rank; r++) begin
        acc = 0;
        for (int j = 0; j < m_inn; j++) acc += longint'(tb_v[r][j]) * longint'(m_in[j]);
        t[r] = sat(acc >>> m_shift);
      end
      p = 0;
      for (int r = 0; r < m_rank; r++) p += longint'(tb_u[k][r]) * t[r];
      if (p <= 0) return 16'h0000;
    end
    acc = 0;
    for (int j = 0; j < m_inn; j++) acc += longint'(tb_w[k][j]) * longint'(m_in[j]);
    if (acc < 0) acc = 0;
    return 16'(sat(acc >>> m_shift));
  endfunction

  function automatic logic [15:0] kaddr(input int k, input logic [3:0] junk);
    logic [11:0] kk;
    kk = 12'(k);
    return {kk[5:0], junk, kk[11:6]};
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    tick();
    write_en   = 1'b0;
  endtask

  task automatic cfg(input int inn, input int outn, input int rank, input int shift);
    m_inn = inn; m_outn = outn; m_rank = rank; m_shift = shift;
    wr(16'hF000, 16'(inn));
    wr(16'hF001, 16'(outn));
    wr(16'hF002, 16'(rank));
    wr(16'hF003, 16'(shift));
    for (int j = 0; j < inn; j++) wr(16'(j), 16'(m_in[j]));
  endtask

  task automatic load_dut(input int nk);
    for (int k = 0; k < nk; k++) begin
      for (int j = 0; j < 64; j++) dut.w_mem[k][j] = 16'(tb_w[k][j]);
      for (int r = 0; r < 8; r++) dut.u_mem[k][r] = 16'(tb_u[k][r]);
    end
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 64; j++) dut.v_mem[r][j] = 16'(tb_v[r][j]);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 128; k++) begin
      for (int j = 0; j < 64; j++) tb_w[k][j] = 0;
      for (int r = 0; r < 8; r++) tb_u[k][r] = 0;
    end
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 64; j++) tb_v[r][j] = 0;
  endtask

  task automatic wait_irq(output int cycles, output bit tmo);
    cycles = 0;
    while (interrupt !== 1'b1 && cycles < 30000) begin
      tick();
      cycles++;
    end
    tmo = (interrupt !== 1'b1);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output bit tmo);
    int n;
    read_en   = 1'b1;
    read_addr = a;
    tick();
    read_en = 1'b0;
    n = 0;
    while (read_data_vld !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tmo = (read_data_vld !== 1'b1);
    d = read_data;
    read_data_rdy = 1'b1;
    tick();
    read_data_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int j = 0; j < 64; j++) m_in[j] = 0;
    checks++; if (write_rdy !== 1'b1) begin errors++; $display("FAIL reset_write_rdy: got %b expected 1", write_rdy); end
    checks++; if (read_rdy !== 1'b1) begin errors++; $display("FAIL reset_read_rdy: got %b expected 1", read_rdy); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %b expected 0", interrupt); end
    checks++; if (read_data_vld !== 1'b0) begin errors++; $display("FAIL reset_read_vld: got %b expected 0", read_data_vld); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 00000000", read_data); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    bit tmo;
    clear_model();
    tb_w[0][0] = 1; tb_w[0][1] = 2;
    m_in[0] = 3; m_in[1] = 4;
    load_dut(1);
    cfg(2, 1, 0, 0);
    wr(16'hF004, 16'h0001);
    wait_irq(basic_cycles, tmo);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_interrupt: got %b expected 1", interrupt); end
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h0000000B) begin errors++; $display("FAIL basic_read: got %h (timeout %0d) expected 0000000b", d, tmo); end
  endtask

  task automatic test_relu();
    logic [31:0] d;
    bit tmo;
    int cyc;
    tb_w[0][0] = -5; tb_w[0][1] = 1;
    load_dut(1);
    wr(16'hF004, 16'h0001);
    wait_irq(cyc, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL relu_interrupt: got timeout expected interrupt"); end
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h00000000) begin errors++; $display("FAIL relu_read: got %h expected 00000000", d); end
  endtask

  task automatic test_pred_skip();
    logic [31:0] d;
    bit tmo;
    int cyc;
    tb_w[0][0] = 1; tb_w[0][1] = 2;
    tb_v[0][0] = 1; tb_v[0][1] = 0;
    tb_u[0][0] = -1;
    load_dut(1);
    wr(16'hF002, 16'd1);
    wr(16'hF004, 16'h0001);
    wait_irq(cyc, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL skip_interrupt: got timeout expected interrupt"); end
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h00000000) begin errors++; $display("FAIL skip_read: got %h expected 00000000", d); end
    checks++; if (cyc >= basic_cycles) begin errors++; $display("FAIL skip_cycles: got %0d expected below %0d", cyc, basic_cycles); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    bit tmo;
    int cyc;
    clear_model();
    tb_w[0][0] = 100; tb_w[0][1] = 100;
    m_in[0] = 200; m_in[1] = 200;
    load_dut(1);
    cfg(2, 1, 0, 0);
    wr(16'hF004, 16'h0001);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL sat_irq_clear: got %b expected 0", interrupt); end
    checks++; if (write_rdy !== 1'b0) begin errors++; $display("FAIL sat_busy_write_rdy: got %b expected 0", write_rdy); end
    wr(16'h0000, 16'h0000);
    wait_irq(cyc, tmo);
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h00007FFF) begin errors++; $display("FAIL sat_read: got %h expected 00007fff", d); end
    wr(16'hF004, 16'h0001);
    wait_irq(cyc, tmo);
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h00007FFF) begin errors++; $display("FAIL sat_dropped_write: got %h expected 00007fff", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    bit tmo;
    int cyc;
    for (int round = 0; round < 2; round++) begin
      clear_model();
      for (int k = 0; k < 128; k++) begin
        for (int j = 0; j < 64; j++) tb_w[k][j] = int'($urandom_range(0, 4000)) - 2000;
        for (int r = 0; r < 8; r++) tb_u[k][r] = int'($urandom_range(0, 4000)) - 2000;
      end
      for (int r = 0; r < 8; r++)
        for (int j = 0; j < 64; j++) tb_v[r][j] = int'($urandom_range(0, 4000)) - 2000;
      for (int j = 0; j < 64; j++) m_in[j] = int'($urandom_range(0, 4000)) - 2000;
      load_dut(128);
      cfg(int'($urandom_range(1, 64)), int'($urandom_range(66, 100)),
          (round == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, 8)),
          int'($urandom_range(0, 15)));
      wr(16'hF004, 16'h0001);
      wait_irq(cyc, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rand_interrupt: got timeout expected interrupt"); end
      for (int k = 0; k < m_outn; k++) begin
        exp_out[k] = model_out(k);
        e = {4'b0, 12'(k), exp_out[k]};
        rd(kaddr(k, 4'($urandom)), d, tmo);
        checks++; if (tmo || d !== e) begin errors++; $display("FAIL rand_read k=%0d: got %h expected %h", k, d, e); end
      end
      e = {4'b0, 12'(m_outn), 16'h0};
      rd(kaddr(m_outn, 4'hF), d, tmo);
      checks++; if (tmo || d !== e) begin errors++; $display("FAIL rand_oob: got %h expected %h", d, e); end
      e = {4'b0, 12'hFFF, 16'h0};
      rd(16'hFC3F, d, tmo);
      checks++; if (tmo || d !== e) begin errors++; $display("FAIL rand_oob_top: got %h expected %h", d, e); end
    end
  endtask

  task automatic test_read_backpressure();
    logic [31:0] e;
    e = {4'b0, 12'h041, exp_out[65]};
    read_en   = 1'b1;
    read_addr = 16'h0401;
    tick();
    read_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (read_data_vld !== 1'b1) begin errors++; $display("FAIL bp_vld c=%0d: got %b expected 1", c, read_data_vld); end
      checks++; if (read_data !== e) begin errors++; $display("FAIL bp_data c=%0d: got %h expected %h", c, read_data, e); end
      checks++; if (read_rdy !== 1'b0) begin errors++; $display("FAIL bp_read_rdy c=%0d: got %b expected 0", c, read_rdy); end
      tick();
    end
    read_data_rdy = 1'b1;
    tick();
    read_data_rdy = 1'b0;
    checks++; if (read_data_vld !== 1'b0) begin errors++; $display("FAIL bp_release_vld: got %b expected 0", read_data_vld); end
    checks++; if (read_rdy !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %b expected 1", read_rdy); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    bit tmo;
    cfg(64, 50, 4, 3);
    wr(16'hF004, 16'h0001);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 64; j++) m_in[j] = 0;
    checks++; if (write_rdy !== 1'b1) begin errors++; $display("FAIL abort_write_rdy: got %b expected 1", write_rdy); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL abort_interrupt: got %b expected 0", interrupt); end
    for (int c = 0; c < 20; c++) tick();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL abort_late_interrupt: got %b expected 0", interrupt); end
    rd(16'h0000, d, tmo);
    checks++; if (tmo || d !== 32'h0) begin errors++; $display("FAIL abort_cfg_cleared: got %h expected 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_pred_skip();
    test_saturation();
    test_random();
    test_read_backpressure();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
